multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_HANDSHAKE, default 1, meaning 1 = memory states wait for mem_ready, 0 = mem_ready treated as constant 1.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory has completed the current read or write this cycle.
REQ-006 alu_op  output  2  ALUOp to the ALU control decoder: 00 add (LW/SW/PC), 01 subtract (BEQ), 10 R-type funct decode, 11 ORI.
REQ-007 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  output  1 each  standard multicycle datapath strobes/selects.
REQ-008 alu_src_b  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm shifted left 2.
REQ-009 pc_source  output  2  00 ALU result, 01 ALUOut (branch target).
REQ-010 state  output  4  current state encoding, for debug.
REQ-011 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-012 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BEQ=8, ORIEXEC=9, ORIWB=10; codes 11-15 are unused.
REQ-013 Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ORI 001101.
REQ-014 Transitions:
- FETCH->DECODE when mem_ready=1, else stay in FETCH.
- DECODE: LW/SW->MEMADR, R->EXEC, BEQ->BEQ, ORI->ORIEXEC, any other opcode->FETCH with illegal_op=1 in that DECODE cycle.
- MEMADR: LW->MEMRD, SW->MEMWR.
- MEMRD->MEMWB when mem_ready=1, else stay.
- MEMWR->FETCH when mem_ready=1, else stay.
- MEMWB, RCOMP, BEQ, ORIWB->FETCH.
- EXEC->RCOMP, ORIEXEC->ORIWB.
- Unused codes->FETCH.
REQ-015 Outputs are Moore-decoded from state, except that ir_write and pc_write in FETCH are gated by mem_ready; every output not listed for a state is 0.
REQ-016 Per-state asserted outputs:
- FETCH: mem_read, alu_src_b=01, alu_op=00, ir_write and pc_write when mem_ready.
- DECODE: alu_src_b=11, alu_op=00.
- MEMADR: alu_src_a, alu_src_b=10, alu_op=00.
- MEMRD: mem_read, iord.
- MEMWB: reg_write, mem_to_reg.
- MEMWR: mem_write, iord.
- EXEC: alu_src_a, alu_op=10.
- RCOMP: reg_write, reg_dst, alu_op=10.
- BEQ: alu_src_a, alu_op=01, pc_write_cond, pc_source=01.
- ORIEXEC: alu_src_a, alu_src_b=10, alu_op=11.
- ORIWB: reg_write, alu_op=11.
REQ-017 Instruction latency with mem_ready held at 1: LW 5 cycles; SW and R-type 4 cycles; ORI 4 cycles; BEQ 3 cycles.
REQ-018 The opcode is sampled in DECODE and MEMADR only; opcode changes in other states have no effect.
REQ-019 mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Reset
REQ-020 When rst_n=0, state becomes FETCH immediately, regardless of clk.
REQ-021 While rst_n=0, all outputs are 0, including the FETCH strobes and illegal_op.
REQ-022 Reset asserted mid-instruction aborts that instruction; no write strobe is asserted after reset is asserted.
REQ-023 FETCH outputs resume in the first cycle after rst_n rises.

Verification
REQ-024 LW (100011) with mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-025 SW with mem_ready low for 3 cycles in MEMWR -> state stays 5 for 4 cycles with mem_write=1 throughout, then returns to 0.
REQ-026 R-type then ORI back-to-back -> alu_op=10 in states 6 and 7, then alu_op=11 in states 9 and 10; reg_dst=1 only in state 7.
REQ-027 BEQ -> state sequence 0,1,8,0; in state 8 pc_write_cond=1, alu_op=01, pc_source=01.
REQ-028 opcode 111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state 0, no write strobes asserted.
REQ-029 rst_n pulled low asynchronously in MEMRD -> state=0 and all outputs 0 before the next clk edge; after rst_n rises, FETCH with mem_read=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath: walks each instruction through its
// fetch/decode/execute states and Moore-decodes the datapath strobes from the current state.
module multicycle_control #(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef enum logic [ST_W-1:0] {
    S_FETCH   = ST_W'(0),
    S_DECODE  = ST_W'(1),
    S_MEMADR  = ST_W'(2),
    S_MEMRD   = ST_W'(3),
    S_MEMWB   = ST_W'(4),
    S_MEMWR   = ST_W'(5),
    S_EXEC    = ST_W'(6),
    S_RCOMP   = ST_W'(7),
    S_BEQ     = ST_W'(8),
    S_ORIEXEC = ST_W'(9),
    S_ORIWB   = ST_W'(10)
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   ready;

  // With the handshake disabled every memory access completes in one cycle.
  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state = state_q;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d       = state_q;
    alu_op        = ALU_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = ready;
        pc_write  = ready;
        if (ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_BR;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ORI:       state_d = S_ORIEXEC;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        // Opcode is re-sampled here; anything other than LW/SW abandons the access.
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (ready) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
        state_d   = S_RCOMP;
      end
      S_RCOMP: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = ALU_FUNC;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_ORIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OR;
        state_d   = S_ORIWB;
      end
      S_ORIWB: begin
        reg_write = 1'b1;
        alu_op    = ALU_OR;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Hold every strobe low while reset is asserted, including the FETCH ones.
    if (!rst_n) begin
      alu_op        = ALU_ADD;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
    end
  end

endmodule
